// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter for the single FIFO write port, shared by NUM_REQ
//   valid/ready producers. Each grant carries at most MAX_BURST beats. The
//   block also drives the FIFO read strobe for one consumer and tracks
//   occupancy, so the FIFO never overflows or underflows.
//
// Ports
//   clk, reset             clock (rising edge); asynchronous active-high reset
//   req_valid/req_data     producer i beat and data (slice [i*DATA_W +: DATA_W])
//   req_ready              one-hot strobe: beat of the granted producer accepted
//   wr_en/data_in          FIFO write strobe and write data
//   rd_req                 consumer asks for one entry
//   rd_en                  FIFO read strobe
//   data_out               FIFO read data, valid the cycle after rd_en
//   rd_valid/rd_data       read data returned to the consumer
//   count/full/empty       registered occupancy and its decodes
//   grant_valid/grant_id   arbiter holds a grant / current grantee
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_BURST  = 4,
    localparam int GID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1),
    localparam int BEAT_W    = $clog2(MAX_BURST + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       wr_en,
    output logic [DATA_W-1:0]          data_in,
    input  logic                       rd_req,
    output logic                       rd_en,
    input  logic [DATA_W-1:0]          data_out,
    output logic                       rd_valid,
    output logic [DATA_W-1:0]          rd_data,
    output logic [CNT_W-1:0]           count,
    output logic                       full,
    output logic                       empty,
    output logic                       grant_valid,
    output logic [GID_W-1:0]           grant_id
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [GID_W-1:0]   grant_id_q, grant_id_d;
    logic [GID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               rd_valid_q, rd_valid_d;

    logic [GID_W-1:0]   rr_pick;
    logic               rr_found;
    logic [GID_W-1:0]   rr_cand;
    int                 rr_idx;
    logic [DATA_W-1:0]  grant_data;
    logic               beat;

    // Successor of a producer index, wrapping at NUM_REQ (which need not be a
    // power of two).
    function automatic logic [GID_W-1:0] wrap_inc(input logic [GID_W-1:0] id);
        return (id == GID_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
    endfunction

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = rr_ptr_q;
        rr_cand  = '0;
        rr_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_idx  = (int'(rr_ptr_q) + k) % NUM_REQ;
            rr_cand = GID_W'(rr_idx);
            if (!rr_found && req_valid[rr_cand]) begin
                rr_found = 1'b1;
                rr_pick  = rr_cand;
            end
        end
    end

    // Data slice of the current grantee.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (GID_W'(i) == grant_id_q) begin
                grant_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // A beat needs the grantee's valid and room in the FIFO; a read in the
    // same cycle does not free room for it (no bypass).
    assign beat = (state_q == GRANT) && req_valid[grant_id_q] && !full;

    // Arbitration FSM: next state, grant bookkeeping.
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    state_d    = GRANT;
                    grant_id_d = rr_pick;
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                // While full the grant is frozen: no beat, no release.
                if (!full) begin
                    if (beat && (beat_cnt_q != BEAT_W'(MAX_BURST - 1))) begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end else begin
                        // Either the grantee dropped valid or the burst is
                        // complete with this beat.
                        state_d  = IDLE;
                        rr_ptr_d = wrap_inc(grant_id_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write-side outputs are combinational with the beat.
    always_comb begin
        req_ready = '0;
        if (beat) begin
            req_ready[grant_id_q] = 1'b1;
        end
    end

    assign wr_en   = beat;
    assign data_in = beat ? grant_data : '0;

    // Read side and occupancy.
    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_W'(FIFO_DEPTH));
    assign rd_en      = rd_req && !empty;
    assign rd_valid_d = rd_en;

    always_comb begin
        count_d = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Register stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign count       = count_q;
    assign grant_valid = (state_q == GRANT);
    assign grant_id    = grant_id_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_valid_q ? data_out : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_W=8, FIFO_DEPTH=16,
//   MAX_BURST=4). A small queue stands in for the FIFO behind the arbiter.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        wr_en;
    logic [7:0]  data_in;
    logic        rd_req;
    logic        rd_en;
    logic [7:0]  data_out;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic        grant_valid;
    logic [1:0]  grant_id;

    int checks = 0;
    int errors = 0;

    fifo_wr_arbiter #(
        .NUM_REQ(4), .DATA_W(8), .FIFO_DEPTH(16), .MAX_BURST(4)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .wr_en(wr_en), .data_in(data_in),
        .rd_req(rd_req), .rd_en(rd_en), .data_out(data_out),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .count(count), .full(full), .empty(empty),
        .grant_valid(grant_valid), .grant_id(grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO stand-in: pop before push, read data one cycle after rd_en.
    logic [7:0] fifo_q[$];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_q.delete();
            data_out <= 8'h00;
        end else begin
            if (rd_en && fifo_q.size() > 0) data_out <= fifo_q.pop_front();
            if (wr_en) fifo_q.push_back(data_in);
        end
    end

    localparam logic [31:0] DATA_DEFAULT = {8'h43, 8'h32, 8'h21, 8'h10};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " count"},       32'(count),       32'd0);
        chk({tag, " empty"},       32'(empty),       32'd1);
        chk({tag, " full"},        32'(full),        32'd0);
        chk({tag, " grant_valid"}, 32'(grant_valid), 32'd0);
        chk({tag, " grant_id"},    32'(grant_id),    32'd0);
        chk({tag, " wr_en"},       32'(wr_en),       32'd0);
        chk({tag, " req_ready"},   32'(req_ready),   32'd0);
        chk({tag, " data_in"},     32'(data_in),     32'd0);
        chk({tag, " rd_en"},       32'(rd_en),       32'd0);
        chk({tag, " rd_valid"},    32'(rd_valid),    32'd0);
        chk({tag, " rd_data"},     32'(rd_data),     32'd0);
    endtask

    task automatic do_reset();
        req_valid = 4'h0;
        rd_req    = 1'b0;
        req_data  = DATA_DEFAULT;
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
    endtask

    typedef struct {
        logic [3:0] rv;
        logic       rd;
        logic       wr;
        logic [3:0] rdy;
        logic [7:0] din;
        logic       gv;
        logic [1:0] gid;
        logic [4:0] cnt;
        logic       full;
        logic       empty;
        logic       rden;
        logic       rvld;
        logic [7:0] rdat;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int  nb;
        int  k;
        logic acc;
        logic exp_wr;
        logic done;

        // rv  rd    wr    rdy   din    gv    gid   cnt   full  empty rden  rvld  rdat
        vecs[0]  = '{4'hF, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 2'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{4'hF, 1'b0, 1'b1, 4'h1, 8'h10, 1'b1, 2'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{4'hF, 1'b0, 1'b1, 4'h1, 8'h10, 1'b1, 2'd0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[3]  = '{4'hF, 1'b1, 1'b1, 4'h1, 8'h10, 1'b1, 2'd0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[4]  = '{4'hF, 1'b0, 1'b1, 4'h1, 8'h10, 1'b1, 2'd0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10};
        vecs[5]  = '{4'hF, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 2'd0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[6]  = '{4'hF, 1'b0, 1'b1, 4'h2, 8'h21, 1'b1, 2'd1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[7]  = '{4'hF, 1'b0, 1'b1, 4'h2, 8'h21, 1'b1, 2'd1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[8]  = '{4'h9, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 2'd1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[9]  = '{4'h9, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 2'd1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[10] = '{4'h9, 1'b0, 1'b1, 4'h8, 8'h43, 1'b1, 2'd3, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[11] = '{4'h1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 2'd3, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[12] = '{4'h0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 2'd3, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[13] = '{4'h0, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 2'd3, 5'd6, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[14] = '{4'h0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 2'd3, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10};

        // Power-on reset.
        reset     = 1'b1;
        req_valid = 4'h0;
        req_data  = DATA_DEFAULT;
        rd_req    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        @(negedge clk) reset = 1'b0;

        // Table: contention, drop of valid, skip of idle requester, reads.
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            req_valid = vecs[i].rv;
            rd_req    = vecs[i].rd;
            @(negedge clk);
            chk($sformatf("v%0d wr_en", i),       32'(wr_en),       32'(vecs[i].wr));
            chk($sformatf("v%0d req_ready", i),   32'(req_ready),   32'(vecs[i].rdy));
            chk($sformatf("v%0d data_in", i),     32'(data_in),     32'(vecs[i].din));
            chk($sformatf("v%0d grant_valid", i), 32'(grant_valid), 32'(vecs[i].gv));
            chk($sformatf("v%0d grant_id", i),    32'(grant_id),    32'(vecs[i].gid));
            chk($sformatf("v%0d count", i),       32'(count),       32'(vecs[i].cnt));
            chk($sformatf("v%0d full", i),        32'(full),        32'(vecs[i].full));
            chk($sformatf("v%0d empty", i),       32'(empty),       32'(vecs[i].empty));
            chk($sformatf("v%0d rd_en", i),       32'(rd_en),       32'(vecs[i].rden));
            chk($sformatf("v%0d rd_valid", i),    32'(rd_valid),    32'(vecs[i].rvld));
            chk($sformatf("v%0d rd_data", i),     32'(rd_data),     32'(vecs[i].rdat));
        end

        // Single producer, data 0x10..0x17: beats at cycles 1-4 and 6-9.
        do_reset();
        k   = 0;
        nb  = 0;
        acc = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (acc) k++;
            req_valid     = 4'h1;
            req_data[7:0] = 8'h10 + 8'(k);
            @(negedge clk);
            exp_wr = ((c >= 1) && (c <= 4)) || ((c >= 6) && (c <= 9));
            chk($sformatf("single c%0d wr_en", c), 32'(wr_en), 32'(exp_wr));
            if (exp_wr) begin
                chk($sformatf("single c%0d data_in", c), 32'(data_in), 32'h10 + 32'(nb));
                nb++;
            end
            acc = req_ready[0];
        end
        @(posedge clk);
        #1;
        req_valid = 4'h0;
        @(negedge clk);
        chk("single count", 32'(count), 32'd8);
        for (int j = 0; j < 9; j++) begin
            @(posedge clk);
            #1;
            rd_req = (j < 8);
            @(negedge clk);
            if (j >= 1) begin
                chk($sformatf("order r%0d rd_valid", j), 32'(rd_valid), 32'd1);
                chk($sformatf("order r%0d rd_data", j),  32'(rd_data),  32'h10 + 32'(j - 1));
            end
        end
        chk("drained empty", 32'(empty), 32'd1);
        @(posedge clk);
        #1;
        rd_req = 1'b1;
        @(negedge clk);
        chk("rd at empty rd_en", 32'(rd_en), 32'd0);
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        @(negedge clk);
        chk("rd at empty rd_valid", 32'(rd_valid), 32'd0);

        // Producer 2 drops after 2 beats; producer 3 is next, not producer 0.
        do_reset();
        @(posedge clk); #1; req_valid = 4'h4;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("drop c1 req_ready", 32'(req_ready), 32'h4);
        @(posedge clk); #1;
        @(negedge clk);
        chk("drop c2 req_ready", 32'(req_ready), 32'h4);
        @(posedge clk); #1; req_valid = 4'h9;
        @(negedge clk);
        chk("drop c3 wr_en", 32'(wr_en), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("drop c4 grant_valid", 32'(grant_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("drop c5 grant_id", 32'(grant_id), 32'd3);
        chk("drop c5 req_ready", 32'(req_ready), 32'h8);

        // Fill to 16 under full contention, stall, then one read frees a slot.
        do_reset();
        @(posedge clk); #1; req_valid = 4'hF;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            chk($sformatf("fill c%0d ready onehot0", c), 32'($onehot0(req_ready)), 32'd1);
            if (count == 5'd16) done = 1'b1;
        end
        chk("fill reached 16", 32'(done), 32'd1);
        @(negedge clk);
        chk("full flag", 32'(full), 32'd1);
        chk("full wr_en", 32'(wr_en), 32'd0);
        chk("full grant held", 32'(grant_valid), 32'd1);
        chk("full grant_id", 32'(grant_id), 32'd0);
        @(posedge clk); #1; rd_req = 1'b1;
        @(negedge clk);
        chk("full rd_en", 32'(rd_en), 32'd1);
        chk("full no bypass wr_en", 32'(wr_en), 32'd0);
        @(posedge clk); #1; rd_req = 1'b0;
        @(negedge clk);
        chk("after read count", 32'(count), 32'd15);
        chk("after read full", 32'(full), 32'd0);
        chk("after read wr_en", 32'(wr_en), 32'd1);
        chk("after read data_in", 32'(data_in), 32'h10);
        @(negedge clk);
        chk("refill count", 32'(count), 32'd16);

        // Reset mid-burst at count 7.
        do_reset();
        @(posedge clk); #1; req_valid = 4'h1;
        done = 1'b0;
        for (int c = 0; c < 30 && !done; c++) begin
            @(negedge clk);
            if (count == 5'd7 && wr_en) done = 1'b1;
        end
        chk("reached count 7 mid-burst", 32'(done), 32'd1);
        #2;
        rd_req = 1'b1;
        reset  = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        reset     = 1'b0;
        rd_req    = 1'b0;
        req_valid = 4'hF;
        @(negedge clk);
        chk("restart grant_valid", 32'(grant_valid), 32'd1);
        chk("restart grant_id", 32'(grant_id), 32'd0);
        chk("restart req_ready", 32'(req_ready), 32'h1);
        chk("restart count", 32'(count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter and occupancy controller for the team's 8-bit FIFO DUT. It shares the FIFO's single write port (`wr_en`/`data_in`) between `NUM_REQ` valid/ready producers, with bounded bursts per grant. It also drives the FIFO read port (`rd_en`) for a single consumer. It tracks occupancy so the FIFO never overflows or underflows, and sits between producer agents and the FIFO in the `dut_if` environment.

## Interface
Parameters:
- `NUM_REQ`, 4, number of producers (2..8)
- `DATA_W`, 8, data width; matches FIFO `data_in`/`data_out`
- `FIFO_DEPTH`, 16, FIFO capacity in entries
- `MAX_BURST`, 4, maximum beats per grant (>=1)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  NUM_REQ  producer i has a beat
- `req_data`  in  NUM_REQ*DATA_W  producer i data, slice [i*DATA_W +: DATA_W]
- `req_ready`  out  NUM_REQ  beat of producer i accepted this cycle
- `wr_en`  out  1  FIFO write strobe
- `data_in`  out  DATA_W  FIFO write data
- `rd_req`  in  1  consumer requests one entry
- `rd_en`  out  1  FIFO read strobe
- `data_out`  in  DATA_W  FIFO read data, valid 1 cycle after `rd_en`
- `rd_valid`  out  1  `rd_data` valid
- `rd_data`  out  DATA_W  read data to consumer
- `count`  out  $clog2(FIFO_DEPTH+1)  current occupancy
- `full`, `empty`  out  1  count==FIFO_DEPTH / count==0
- `grant_valid`  out  1  arbiter in GRANT state
- `grant_id`  out  $clog2(NUM_REQ)  current grantee

## Operation
- FSM states: IDLE, GRANT. Registers: `grant_id`, round-robin pointer `rr_ptr`, `beat_cnt`, `count`.
- IDLE:
  - If any `req_valid`, grant the first set bit searching upward from `rr_ptr` with wrap.
  - Go to GRANT with `beat_cnt`=0. No beat is taken in IDLE (1-cycle arbitration bubble).
- GRANT, beat condition: `req_valid[grant_id] && !full`.
  - On a beat: `wr_en`=1, `data_in`=slice of `grant_id`, `req_ready[grant_id]`=1, `beat_cnt`++. All outputs are combinational in the same cycle.
- GRANT, release (to IDLE, `rr_ptr` <= (`grant_id`+1) mod NUM_REQ):
  - `req_valid[grant_id]`==0 (no beat that cycle), or
  - a beat occurs with `beat_cnt`==MAX_BURST-1.
- `full` in GRANT: stall. No beat, no release, `beat_cnt` held.
- Writes never complete when `full`, even if `rd_en` is asserted the same cycle (no bypass).
- Read side: `rd_en` = `rd_req && !empty` (combinational). `rd_valid` <= `rd_en`; `rd_data` = `data_out` when `rd_valid`, else 0.
- Occupancy: `count` +1 on `wr_en` only, -1 on `rd_en` only, unchanged on both or neither.
- Other requesters' `req_ready` stay 0 while a grant is held; their `req_valid` is ignored until re-arbitration.

## Timing
- Reset values (asynchronous): state=IDLE, `rr_ptr`=0, `grant_id`=0, `beat_cnt`=0, `count`=0, `grant_valid`=0, `rd_valid`=0, `empty`=1, `full`=0. Outputs `wr_en`, `rd_en`, `req_ready`, `data_in`, `rd_data` all 0.
- Reset asserted mid-burst aborts the burst. Data already written is not counted after reset; the FIFO is reset by the same `reset`.
- Request to first beat: 1 cycle (request in IDLE at cycle N, beat at N+1).
- Back-to-back beats within a grant: 1 per cycle. Between grants: 1 idle cycle.
- `rd_en` at cycle N gives `rd_valid`/`rd_data` at N+1.
- `full`/`empty` are decoded from the registered `count`. They reflect an update the cycle after the strobe.
- Throughput bound: MAX_BURST beats per MAX_BURST+1 cycles under continuous contention.

## Test plan
- Single producer 0 holds valid with data 0x10..0x17, MAX_BURST=4 -> beats at cycles 1-4, bubble, beats 6-9. FIFO order is 0x10..0x17. `count` reaches 8.
- All 4 producers valid continuously -> grant order 0,1,2,3,0. Each grant is exactly 4 beats. `req_ready` is one-hot or zero every cycle.
- Producer 2 drops valid after 2 beats -> release, `rr_ptr`=3, producer 3 granted next even though producer 0 is valid.
- Fill to 16 with no reads -> `full`=1, `wr_en`=0, grant held. Assert `rd_req` one cycle -> `count` 15, write resumes next cycle.
- Simultaneous `wr_en` and `rd_en` at count 5 -> `count` stays 5. `rd_valid` next cycle with the oldest entry. `rd_req` at `empty` -> `rd_en`=0, `rd_valid`=0.
- Assert `reset` mid-burst at count 7 -> all outputs at reset values immediately. Arbitration restarts from producer 0.
